apb_arbiter: RTL and testbench

Two-requester APB master arbiter and sequencer that shares the peripheral APB bus between the CPU core and the instruction-memory loader/debug port. It accepts one transfer request per requester, grants the bus round-robin, and drives the APB SETUP/ACCESS phases with PREADY handshake. It also returns a one-cycle completion pulse with read data and error status. It sits between the CPU's APB request outputs (select, 8-bit address, 21-bit data) and the peripheral select/decode fabric.

---
 rtl/apb_arb_pkg.sv | 23 ++
 rtl/apb_arbiter_if.sv | 27 ++
 rtl/apb_rr_pick.sv | 21 ++
 rtl/apb_arbiter.sv | 153 +++++++++++++++
 tb/tb_apb_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter: FSM states, default widths
// and the packed request latch layout.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 21;
  localparam int SEL_W_DEF  = 8;

  typedef struct packed {
    logic                  wr;
    logic [SEL_W_DEF-1:0]  sel;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_arbiter_if.sv
// APB bus bundle between the arbiter (master) and the peripheral fabric (slave).
interface apb_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 21,
  parameter int SEL_W  = 8
);

  logic [SEL_W-1:0]  PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_rr_pick.sv
// Combinational two-way round-robin pick: on a tie the requester that was not
// served last wins.
module apb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       idx,
  output logic       valid
);

  // Winner select from the request pair and last-served pointer
  always_comb begin
    valid = |req;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master arbiter/sequencer (CPU = 0, loader = 1).
// Define APB_ARB_TIMEOUT_EN to enable the ACCESS-phase wait counter and timeout abort.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WR0,
  input  logic              WR1,
  input  logic [SEL_W-1:0]  SEL0,
  input  logic [SEL_W-1:0]  SEL1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  apb_arbiter_if.master     apb
);

  arb_state_t state_r;
  apb_req_t   req_r;
  apb_req_t   pick_req_s;
  logic       last_r;
  logic       owner_r;
  logic       pick_idx_s;
  logic       pick_valid_s;
  logic       timeout_s;
  logic       acc_done_s;

  apb_rr_pick u_pick (
    .req   ({REQ1, REQ0}),
    .last  (last_r),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Request fields of the current round-robin winner
  always_comb begin
    pick_req_s = '0;
    if (pick_idx_s) begin
      pick_req_s.wr    = WR1;
      pick_req_s.sel   = SEL_W_DEF'(SEL1);
      pick_req_s.addr  = ADDR_W_DEF'(ADDR1);
      pick_req_s.wdata = DATA_W_DEF'(WDATA1);
    end else begin
      pick_req_s.wr    = WR0;
      pick_req_s.sel   = SEL_W_DEF'(SEL0);
      pick_req_s.addr  = ADDR_W_DEF'(ADDR0);
      pick_req_s.wdata = DATA_W_DEF'(WDATA0);
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_r;

  assign timeout_s = (wait_cnt_r == 8'(TIMEOUT));
`else
  assign timeout_s = 1'b0 && (TIMEOUT > 0);
`endif

  // PREADY wins over a timeout landing in the same cycle
  assign acc_done_s = apb.PREADY | timeout_s;

  // The latch drives the bus directly; its sel field is cleared when ACCESS ends
  assign apb.PSEL   = SEL_W'(req_r.sel);
  assign apb.PWRITE = req_r.wr;
  assign apb.PADDR  = ADDR_W'(req_r.addr);
  assign apb.PWDATA = DATA_W'(req_r.wdata);

  // Transfer sequencer: IDLE -> SETUP -> ACCESS (wait) -> RESP -> IDLE
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      req_r       <= '0;
      last_r      <= 1'b1;
      owner_r     <= 1'b0;
      apb.PENABLE <= 1'b0;
      GNT0        <= 1'b0;
      GNT1        <= 1'b0;
      DONE0       <= 1'b0;
      DONE1       <= 1'b0;
      ERR         <= 1'b0;
      RDATA       <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt_r  <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            state_r    <= SETUP;
            req_r      <= pick_req_s;
            owner_r    <= pick_idx_s;
            GNT0       <= ~pick_idx_s;
            GNT1       <= pick_idx_s;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt_r <= 8'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state_r     <= ACCESS;
        end
        ACCESS: begin
          if (acc_done_s) begin
            state_r     <= RESP;
            req_r.sel   <= '0;
            apb.PENABLE <= 1'b0;
            DONE0       <= ~owner_r;
            DONE1       <= owner_r;
            ERR         <= apb.PREADY ? apb.PSLVERR : 1'b1;
            if (apb.PREADY && !req_r.wr) begin
              RDATA <= apb.PRDATA;
            end
          end else begin
            state_r    <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt_r <= wait_cnt_r + 8'd1;
`endif
          end
        end
        RESP: begin
          state_r <= IDLE;
          last_r  <= owner_r;
          GNT0    <= 1'b0;
          GNT1    <= 1'b0;
          DONE0   <= 1'b0;
          DONE1   <= 1'b0;
          ERR     <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus randomized requesters, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_apb_arbiter;

  localparam int TIMEOUT = 15;
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET;
  logic        REQ0, REQ1, WR0, WR1;
  logic [7:0]  SEL0, SEL1, ADDR0, ADDR1;
  logic [20:0] WDATA0, WDATA1;
  logic        GNT0, GNT1, DONE0, DONE1, ERR;
  logic [20:0] RDATA;

  apb_arbiter_if #(.ADDR_W(8), .DATA_W(21), .SEL_W(8)) bus ();

  apb_arbiter #(.ADDR_W(8), .DATA_W(21), .SEL_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
    .SEL0(SEL0), .SEL1(SEL1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .ERR(ERR), .RDATA(RDATA), .apb(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int n_checks    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one transfer in flight, described by who owns it and how
  // many cycles it has lived (1 = setup cycle, k+1 = k-th access cycle).
  bit          m_busy = 0, m_resp = 0, m_who = 0, m_last = 1, m_err = 0, m_wr = 0;
  int          m_age = 0;
  logic [7:0]  m_sel = 0, m_addr = 0;
  logic [20:0] m_wdata = 0, m_rdata = 0;

  task automatic m_reset();
    m_busy = 0; m_resp = 0; m_who = 0; m_last = 1; m_err = 0; m_age = 0;
    m_wr = 0; m_sel = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
  endtask

  task automatic m_step();
    if (m_resp) begin
      m_resp = 0;
      m_last = m_who;
      m_err  = 0;
    end else if (!m_busy) begin
      if (REQ0 || REQ1) begin
        m_who = (REQ0 && REQ1) ? !m_last : REQ1;
        if (m_who) begin
          m_wr = WR1; m_sel = SEL1; m_addr = ADDR1; m_wdata = WDATA1;
        end else begin
          m_wr = WR0; m_sel = SEL0; m_addr = ADDR0; m_wdata = WDATA0;
        end
        m_busy = 1;
        m_age  = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (bus.PREADY) begin
      if (!m_wr) m_rdata = bus.PRDATA;
      m_err  = bus.PSLVERR;
      m_busy = 0;
      m_resp = 1;
    end else if (TO_EN && (m_age - 1 == TIMEOUT + 1)) begin
      m_err  = 1;
      m_busy = 0;
      m_resp = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_outputs();
    vectors++;
    chk("psel", bus.PSEL, m_busy ? m_sel : 8'h00);
    chk("penable", bus.PENABLE, m_busy && m_age >= 2);
    chk("gnt0", GNT0, (m_busy || m_resp) && !m_who);
    chk("gnt1", GNT1, (m_busy || m_resp) && m_who);
    chk("done0", DONE0, m_resp && !m_who);
    chk("done1", DONE1, m_resp && m_who);
    chk("rdata", RDATA, m_rdata);
    if (m_busy) begin
      chk("paddr", bus.PADDR, m_addr);
      chk("pwrite", bus.PWRITE, m_wr);
      chk("pwdata", bus.PWDATA, m_wdata);
    end
    if (m_resp) chk("err", ERR, m_err);
  endtask

  // Model advances on each edge with the inputs present there, then compares
  always @(posedge clk) begin
    if (RESET) m_reset();
    else m_step();
    #1;
    check_outputs();
  end

  task automatic rand_txn0();
    WR0 = 1'($urandom); SEL0 = 8'd1 << ($urandom % 8); ADDR0 = 8'($urandom); WDATA0 = 21'($urandom);
  endtask

  task automatic rand_txn1();
    WR1 = 1'($urandom); SEL1 = 8'd1 << ($urandom % 8); ADDR1 = 8'($urandom); WDATA1 = 21'($urandom);
  endtask

  int  rr_who [4];
  int  rr_t   [4];
  int  cnt;
  bit  seen;
  bit  ab0, ab1;

  initial begin
    RESET = 1'b1;
    REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0; SEL0 = 0; SEL1 = 0;
    ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    @(posedge clk); #2;
    chk("reset_psel", bus.PSEL, 8'h00);
    chk("reset_gnt0", GNT0, 1'b0);
    chk("reset_rdata", RDATA, 21'h0);

    // Single CPU write, zero wait states
    @(negedge clk);
    REQ0 = 1; WR0 = 1; SEL0 = 8'h01; ADDR0 = 8'h03; WDATA0 = 21'h3; bus.PREADY = 1;
    @(posedge clk); #2;
    chk("wr_setup_psel", bus.PSEL, 8'h01);
    chk("wr_setup_penable", bus.PENABLE, 1'b0);
    @(posedge clk); #2;
    chk("wr_access_penable", bus.PENABLE, 1'b1);
    chk("wr_access_paddr", bus.PADDR, 8'h03);
    chk("wr_access_pwdata", bus.PWDATA, 21'h3);
    @(posedge clk); #2;
    chk("wr_done0", DONE0, 1'b1);
    chk("wr_err", ERR, 1'b0);
    chk("wr_rdata", RDATA, 21'h0);
    chk("wr_resp_psel", bus.PSEL, 8'h00);
    @(negedge clk); REQ0 = 0;
    repeat (2) @(negedge clk);

    // Loader read with two wait states
    REQ1 = 1; WR1 = 0; SEL1 = 8'h02; ADDR1 = 8'h10; WDATA1 = 21'h0;
    bus.PRDATA = 21'h0F; bus.PREADY = 0;
    repeat (4) @(posedge clk); #2;
    chk("rd_wait_penable", bus.PENABLE, 1'b1);
    chk("rd_wait_done1", DONE1, 1'b0);
    @(negedge clk); bus.PREADY = 1;
    @(posedge clk); #2;
    chk("rd_done1", DONE1, 1'b1);
    chk("rd_rdata", RDATA, 21'h0F);
    @(negedge clk); REQ1 = 0;
    repeat (2) @(negedge clk);

    // Both requesting continuously: alternate 0,1,0,1 four cycles apart
    REQ0 = 1; WR0 = 1; REQ1 = 1; WR1 = 1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(negedge clk);
      chk("rr_no_overlap", DONE0 & DONE1, 1'b0);
      if (DONE0 || DONE1) begin
        rr_who[cnt] = DONE1 ? 1 : 0;
        rr_t[cnt]   = c;
        cnt++;
      end
    end
    REQ0 = 0; REQ1 = 0;
    chk("rr_count", cnt, 4);
    for (int k = 0; k < cnt; k++) begin
      chk("rr_order", rr_who[k], k % 2);
      if (k > 0) chk("rr_gap", rr_t[k] - rr_t[k-1], 4);
    end
    repeat (2) @(negedge clk);

    // Slave error on a CPU write
    REQ0 = 1; WR0 = 1; bus.PREADY = 1; bus.PSLVERR = 1;
    repeat (3) @(posedge clk); #2;
    chk("slverr_done0", DONE0, 1'b1);
    chk("slverr_err", ERR, 1'b1);
    @(negedge clk); REQ0 = 0; bus.PSLVERR = 0;
    repeat (2) @(negedge clk);

    // PREADY never arrives
    REQ1 = 1; WR1 = 0; bus.PREADY = 0;
`ifdef APB_ARB_TIMEOUT_EN
    repeat (17) @(posedge clk); #2;
    chk("to_penable", bus.PENABLE, 1'b1);
    chk("to_not_done", DONE1, 1'b0);
    @(posedge clk); #2;
    chk("to_done1", DONE1, 1'b1);
    chk("to_err", ERR, 1'b1);
    chk("to_psel", bus.PSEL, 8'h00);
    chk("to_rdata", RDATA, 21'h0F);
`else
    repeat (101) @(posedge clk); #2;
    chk("nto_penable", bus.PENABLE, 1'b1);
    chk("nto_psel", bus.PSEL, 8'h02);
    chk("nto_not_done", DONE1, 1'b0);
    @(negedge clk); bus.PREADY = 1;
    @(posedge clk); #2;
    chk("nto_done1", DONE1, 1'b1);
    chk("nto_err", ERR, 1'b0);
`endif
    @(negedge clk); REQ1 = 0; bus.PREADY = 1;
    repeat (2) @(negedge clk);

    // Reset during ACCESS, then a tie goes to the CPU
    REQ0 = 1; WR0 = 1; bus.PREADY = 0;
    repeat (2) @(posedge clk);
    #3; RESET = 1;
    #1;
    chk("rst_psel", bus.PSEL, 8'h00);
    chk("rst_penable", bus.PENABLE, 1'b0);
    chk("rst_gnt0", GNT0, 1'b0);
    chk("rst_done0", DONE0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    RESET = 0; REQ0 = 1; REQ1 = 1; bus.PREADY = 1;
    @(posedge clk); #2;
    chk("post_rst_gnt0", GNT0, 1'b1);
    chk("post_rst_gnt1", GNT1, 1'b0);
    repeat (2) @(posedge clk); #2;
    chk("post_rst_done0", DONE0, 1'b1);
    @(negedge clk); REQ0 = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (DONE1) seen = 1;
    end
    REQ1 = 0;
    chk("post_rst_second", seen, 1'b1);
    repeat (2) @(negedge clk);

    // Randomized requesters and slave responses
    ab0 = 0; ab1 = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (DONE0) begin
        ab0 = 0; REQ0 = ($urandom % 3 == 0); if (REQ0) rand_txn0();
      end else if (REQ0 && GNT0 && ($urandom % 16 == 0)) begin
        REQ0 = 0; ab0 = 1;
      end else if (!REQ0 && !ab0 && ($urandom % 4 == 0)) begin
        REQ0 = 1; rand_txn0();
      end
      if (DONE1) begin
        ab1 = 0; REQ1 = ($urandom % 3 == 0); if (REQ1) rand_txn1();
      end else if (REQ1 && GNT1 && ($urandom % 16 == 0)) begin
        REQ1 = 0; ab1 = 1;
      end else if (!REQ1 && !ab1 && ($urandom % 4 == 0)) begin
        REQ1 = 1; rand_txn1();
      end
      bus.PREADY  = ($urandom % 4 != 0);
      bus.PSLVERR = ($urandom % 8 == 0);
      bus.PRDATA  = 21'($urandom);
    end
    REQ0 = 0; REQ1 = 0; bus.PREADY = 1;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
